// File: rtl/multicycle_seq.sv
// multicycle_seq: multi-cycle sequencer for the simplified RISC-V core.
// Steps each instruction through FETCH, DECODE, EXEC, MEM and WB. It shares
// the single memory port between instruction fetch and load/store, issues the
// one-cycle IR/MDR/register/PC enables, counts retired instructions, and traps
// illegal opcodes and memory timeouts. ERR is left only through reset.
//
// Parameter:
//   MAX_WAIT      cycles a request may stay unanswered before bus error (2..256)
// Ports:
//   clk           core clock
//   rst_n         synchronous reset, active low
//   run           allows new fetches (looked at only in IDLE and at retire)
//   opcode[6:0]   IR[6:0], valid from DECODE onward
//   mem_rvalid    read data valid / store accepted
//   mem_req       memory request
//   mem_we        write strobe, valid with mem_req
//   mem_addr_sel  0 = PC, 1 = ALU result
//   ir_wen        IR load strobe (response-gated, same cycle)
//   mdr_wen       load-data register strobe (response-gated, same cycle)
//   reg_wen       register-file write strobe
//   pc_wen        PC <= PC+4 strobe
//   illegal       sticky illegal-opcode flag
//   bus_err       sticky memory-timeout flag
//   instret[31:0] retired-instruction counter, wraps
//   state[2:0]    current state, for debug
module multicycle_seq #(
    parameter int MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [6:0]  opcode,
    input  logic        mem_rvalid,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_wen,
    output logic        mdr_wen,
    output logic        reg_wen,
    output logic        pc_wen,
    output logic        illegal,
    output logic        bus_err,
    output logic [31:0] instret,
    output logic [2:0]  state
);

    localparam int WW = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_ERR    = 3'd7
    } state_e;

    state_e          state_q, state_d;
    logic [6:0]      op_q, op_d;
    logic [WW-1:0]   wait_q, wait_d;
    logic            illegal_q, illegal_d;
    logic            bus_err_q, bus_err_d;
    logic [31:0]     instret_q, instret_d;
    logic            mem_req_q, mem_req_d;
    logic            mem_we_q, mem_we_d;
    logic            addr_sel_q, addr_sel_d;
    logic            reg_wen_q, reg_wen_d;
    logic            pc_wb_q, pc_wb_d;
    logic            timeout_s;

    function automatic logic is_legal(input logic [6:0] op);
        logic ok;
        case (op)
            OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE: ok = 1'b1;
            default:                                 ok = 1'b0;
        endcase
        return ok;
    endfunction

    // The wait counter is at its last allowed value for an unanswered request.
    assign timeout_s = (wait_q == WW'(MAX_WAIT - 1));

    // Next-state, counters, sticky flags and the next value of the Moore outputs.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        wait_d    = '0;          // cleared whenever a request is not stalling
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;
        instret_d = instret_q;
        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                if (mem_rvalid) begin
                    state_d = S_DECODE;
                end else if (timeout_s) begin
                    bus_err_d = 1'b1;
                    state_d   = S_ERR;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            S_DECODE: begin
                op_d = opcode;
                if (is_legal(opcode)) begin
                    state_d = S_EXEC;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = S_ERR;
                end
            end
            S_EXEC: begin
                if (op_q == OPC_LOAD || op_q == OPC_STORE) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (mem_rvalid) begin
                    if (op_q == OPC_STORE) begin
                        // A store retires as soon as the memory accepts it.
                        instret_d = instret_q + 32'd1;
                        state_d   = run ? S_FETCH : S_IDLE;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (timeout_s) begin
                    bus_err_d = 1'b1;
                    state_d   = S_ERR;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            S_WB: begin
                instret_d = instret_q + 32'd1;
                state_d   = run ? S_FETCH : S_IDLE;
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                // Unused encoding: park safely in ERR.
                state_d = S_ERR;
            end
        endcase

        // Moore outputs are registered, so derive them from the next state.
        mem_req_d  = (state_d == S_FETCH) || (state_d == S_MEM);
        mem_we_d   = (state_d == S_MEM) && (op_d == OPC_STORE);
        addr_sel_d = (state_d == S_MEM);
        reg_wen_d  = (state_d == S_WB);
        pc_wb_d    = (state_d == S_WB);
    end

    // State, counters, flags and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            op_q       <= 7'd0;
            wait_q     <= '0;
            illegal_q  <= 1'b0;
            bus_err_q  <= 1'b0;
            instret_q  <= 32'd0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            addr_sel_q <= 1'b0;
            reg_wen_q  <= 1'b0;
            pc_wb_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            wait_q     <= wait_d;
            illegal_q  <= illegal_d;
            bus_err_q  <= bus_err_d;
            instret_q  <= instret_d;
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
            addr_sel_q <= addr_sel_d;
            reg_wen_q  <= reg_wen_d;
            pc_wb_q    <= pc_wb_d;
        end
    end

    // Load strobes must coincide with the response, so they are gated live.
    assign ir_wen       = (state_q == S_FETCH) && mem_rvalid;
    assign mdr_wen      = (state_q == S_MEM) && (op_q == OPC_LOAD) && mem_rvalid;
    // PC advances in WB, or on the cycle a store is accepted.
    assign pc_wen       = pc_wb_q || ((state_q == S_MEM) && (op_q == OPC_STORE) && mem_rvalid);
    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr_sel = addr_sel_q;
    assign reg_wen      = reg_wen_q;
    assign illegal      = illegal_q;
    assign bus_err      = bus_err_q;
    assign instret      = instret_q;
    assign state        = state_q;

endmodule

// File: tb/tb_multicycle_seq.sv
// Testbench for multicycle_seq. An instruction-level reference model expands
// each instruction (opcode, fetch delay, memory delay, run at retire) into the
// expected per-cycle output trace and compares it against the design.
module tb_multicycle_seq;

    localparam int MAX_WAIT = 16;

    localparam logic [6:0] OP_OP  = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic [6:0]  opcode = 7'd0;
    logic        mem_rvalid = 1'b0;
    logic        mem_req, mem_we, mem_addr_sel, ir_wen, mdr_wen, reg_wen, pc_wen;
    logic        illegal, bus_err;
    logic [31:0] instret;
    logic [2:0]  state;

    int          n_vec = 0;
    int          n_bad = 0;

    logic [31:0] m_instret = 32'd0;
    logic        m_illegal = 1'b0;
    logic        m_berr = 1'b0;

    always #5 clk = ~clk;

    multicycle_seq #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .mem_rvalid(mem_rvalid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
        .ir_wen(ir_wen), .mdr_wen(mdr_wen), .reg_wen(reg_wen), .pc_wen(pc_wen),
        .illegal(illegal), .bus_err(bus_err), .instret(instret), .state(state)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic legal_op(input logic [6:0] op);
        return (op == OP_OP) || (op == OP_IMM) || (op == OP_LD) || (op == OP_ST);
    endfunction

    // Expected output vector: {state, req, we, sel, ir, mdr, reg, pc, illegal, bus_err}
    function automatic logic [11:0] ev(input logic [2:0] st, input logic req, input logic we,
                                       input logic sel, input logic ir, input logic mdr,
                                       input logic rw, input logic pw);
        return {st, req, we, sel, ir, mdr, rw, pw, m_illegal, m_berr};
    endfunction

    // One clock: drive inputs, compare at the falling edge, return just after next rise.
    task automatic cyc(input logic rv, input logic rn, input logic [6:0] opc,
                       input logic rst_in, input logic [11:0] exp_v);
        mem_rvalid = rv;
        run        = rn;
        opcode     = opc;
        rst_n      = rst_in;
        @(negedge clk);
        check_eq("outputs", {20'd0, state, mem_req, mem_we, mem_addr_sel, ir_wen, mdr_wen,
                             reg_wen, pc_wen, illegal, bus_err}, {20'd0, exp_v});
        check_eq("instret", instret, m_instret);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        m_instret = 32'd0;
        m_illegal = 1'b0;
        m_berr    = 1'b0;
    endtask

    // Idle a few cycles with run low, then raise run so the next cycle is FETCH.
    task automatic go_idle();
        int k;
        k = $urandom_range(0, 2);
        for (int i = 0; i < k; i++)
            cyc(rb(), 1'b0, 7'($urandom), 1'b1, ev(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        cyc(rb(), 1'b1, 7'($urandom), 1'b1, ev(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    endtask

    // ERR holds with every strobe low whatever the inputs do; only reset leaves it.
    task automatic err_and_reset();
        int k;
        k = $urandom_range(2, 4);
        for (int i = 0; i < k; i++)
            cyc(rb(), rb(), 7'($urandom), 1'b1, ev(3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        cyc(rb(), rb(), 7'($urandom), 1'b0, ev(3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        clear_model();
        go_idle();
    endtask

    task automatic finish_instr(input logic run_end);
        if (!run_end) go_idle();
    endtask

    // Expected trace of one instruction; entered with the sequencer in FETCH and
    // always left with it about to be in FETCH again.
    task automatic do_instr(input logic [6:0] op, input int df, input int dm,
                            input logic run_end, input bit rst_mem);
        logic rv;
        logic is_ld;
        logic is_st;
        is_ld = (op == OP_LD);
        is_st = (op == OP_ST);
        for (int i = 0; i < MAX_WAIT; i++) begin
            rv = (i == df);
            cyc(rv, rb(), 7'($urandom), 1'b1, ev(3'd1, 1'b1, 1'b0, 1'b0, rv, 1'b0, 1'b0, 1'b0));
            if (rv) break;
        end
        if (df >= MAX_WAIT) begin
            m_berr = 1'b1;
            err_and_reset();
            return;
        end
        cyc(rb(), rb(), op, 1'b1, ev(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        if (!legal_op(op)) begin
            m_illegal = 1'b1;
            err_and_reset();
            return;
        end
        cyc(rb(), rb(), op, 1'b1, ev(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        if (is_ld || is_st) begin
            for (int j = 0; j < MAX_WAIT; j++) begin
                rv = (j == dm);
                cyc(rv, rv ? run_end : rb(), op, rst_mem ? 1'b0 : 1'b1,
                    ev(3'd4, 1'b1, is_st, 1'b1, 1'b0, rv && is_ld, 1'b0, rv && is_st));
                if (rst_mem) begin
                    clear_model();
                    go_idle();
                    return;
                end
                if (rv) break;
            end
            if (dm >= MAX_WAIT) begin
                m_berr = 1'b1;
                err_and_reset();
                return;
            end
            if (is_st) begin
                m_instret = m_instret + 32'd1;
                finish_instr(run_end);
                return;
            end
        end
        cyc(rb(), run_end, op, 1'b1, ev(3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
        m_instret = m_instret + 32'd1;
        finish_instr(run_end);
    endtask

    initial begin
        logic [6:0] legal_ops [4];
        logic [6:0] op;
        int         df;
        int         dm;
        legal_ops[0] = OP_OP;
        legal_ops[1] = OP_IMM;
        legal_ops[2] = OP_LD;
        legal_ops[3] = OP_ST;

        repeat (2) @(posedge clk);
        #1;
        go_idle();                                        // reset state, then start

        do_instr(OP_IMM, 0, 0, 1'b1, 1'b0);               // ADDI, minimum latency
        do_instr(OP_LD, 0, 3, 1'b1, 1'b0);                // LOAD, 3 stall cycles in MEM
        do_instr(OP_ST, 0, 0, 1'b1, 1'b0);                // STORE, retires in MEM
        do_instr(7'b1110011, 0, 0, 1'b1, 1'b0);           // illegal opcode -> ERR
        do_instr(OP_OP, MAX_WAIT, 0, 1'b1, 1'b0);         // fetch timeout
        do_instr(OP_IMM, MAX_WAIT - 1, 0, 1'b1, 1'b0);    // response on last wait cycle
        do_instr(OP_ST, 2, MAX_WAIT - 1, 1'b0, 1'b0);     // store boundary, then IDLE
        do_instr(OP_LD, 0, MAX_WAIT, 1'b1, 1'b0);         // MEM timeout
        do_instr(OP_OP, 0, 0, 1'b0, 1'b0);                // run dropped at retire
        do_instr(OP_LD, 1, 3, 1'b1, 1'b1);                // reset during MEM

        for (int n = 0; n < 120; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                op = 7'($urandom);
                while (legal_op(op)) op = 7'($urandom);
            end else begin
                op = legal_ops[$urandom_range(0, 3)];
            end
            df = ($urandom_range(0, 9) == 0) ? $urandom_range(4, MAX_WAIT) : $urandom_range(0, 3);
            dm = ($urandom_range(0, 9) == 0) ? $urandom_range(4, MAX_WAIT) : $urandom_range(0, 3);
            do_instr(op, df, dm, ($urandom_range(0, 3) != 0), ($urandom_range(0, 29) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
